// File: rtl/lsu_pkg.sv
// lsu_pkg: shared mode encodings, region type, I/O offsets and lane helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;
  typedef enum logic [1:0] {REG_DMEM, REG_IO_OUT, REG_IO_IN, REG_UNMAPPED} region_e;
  localparam logic [7:0] OFF_LEDR  = 8'h00;
  localparam logic [7:0] OFF_LEDG  = 8'h10;
  localparam logic [7:0] OFF_HEX_L = 8'h20;
  localparam logic [7:0] OFF_HEX_H = 8'h24;
  localparam logic [7:0] OFF_LCD   = 8'h30;
  localparam logic [7:0] OFF_SW    = 8'h00;
  localparam logic [7:0] OFF_KEY   = 8'h10;
  function automatic logic [3:0] byte_en(input logic [2:0] mode, input logic [1:0] off);
    return mode[1:0] == 2'b00 ? 4'b0001 << off :
           mode[1:0] == 2'b01 ? 4'b0011 << off :
           mode == MODE_W     ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    for (int i = 0; i < 4; i++) lane_merge[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/lsu_dmem.sv
// lsu_dmem: single-port synchronous RAM with byte enables, read returns pre-write data
module lsu_dmem #(
  parameter int DMEM_AW = 11
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [DMEM_AW-3:0] addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o
);
  logic [31:0] mem_q [2**(DMEM_AW-2)];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/lsu_aligned.sv
// lsu_aligned: aligned byte-lane load/store unit over sync-read DMEM and memory-mapped I/O
module lsu_aligned
  import lsu_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                DMEM_AW     = 11,
  parameter logic [ADDR_W-1:0] IO_OUT_BASE = 16'h7000,
  parameter logic [ADDR_W-1:0] IO_IN_BASE  = 16'h7800,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [2:0]        mode,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misalign,
  input  logic [31:0]       SW,
  input  logic [31:0]       KEY,
  output logic [31:0]       LEDR,
  output logic [31:0]       LEDG,
  output logic [31:0]       HEX_H,
  output logic [31:0]       HEX_L,
  output logic [31:0]       LCD
);
  localparam int SYNC_W = SYNC_STAGES * 32;
  localparam logic [ADDR_W-1:0] A_LEDR  = IO_OUT_BASE + ADDR_W'(OFF_LEDR);
  localparam logic [ADDR_W-1:0] A_LEDG  = IO_OUT_BASE + ADDR_W'(OFF_LEDG);
  localparam logic [ADDR_W-1:0] A_HEX_L = IO_OUT_BASE + ADDR_W'(OFF_HEX_L);
  localparam logic [ADDR_W-1:0] A_HEX_H = IO_OUT_BASE + ADDR_W'(OFF_HEX_H);
  localparam logic [ADDR_W-1:0] A_LCD   = IO_OUT_BASE + ADDR_W'(OFF_LCD);
  localparam logic [ADDR_W-1:0] A_SW    = IO_IN_BASE + ADDR_W'(OFF_SW);
  localparam logic [ADDR_W-1:0] A_KEY   = IO_IN_BASE + ADDR_W'(OFF_KEY);
  function automatic logic hit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] reg_a);
    return a[ADDR_W-1:2] == reg_a[ADDR_W-1:2];
  endfunction
  logic h_ledr, h_ledg, h_hexl, h_hexh, h_lcd, h_sw, h_key, legal, mis, st;
  logic [3:0] be;
  logic [31:0] wlane, io_rd, dm_rdata, word, ext;
  logic [7:0] b;
  logic [15:0] hw;
  region_e region_d, region_q;
  logic [31:0] ledr_q, ledg_q, hexh_q, hexl_q, lcd_q, io_q;
  logic [SYNC_STAGES-1:0][31:0] sw_q, key_q;
  logic [2:0] mode_q;
  logic [1:0] off_q;
  logic rvalid_q, mis_q;
  always_comb begin
    h_ledr   = hit(addr, A_LEDR);
    h_ledg   = hit(addr, A_LEDG);
    h_hexl   = hit(addr, A_HEX_L);
    h_hexh   = hit(addr, A_HEX_H);
    h_lcd    = hit(addr, A_LCD);
    h_sw     = hit(addr, A_SW);
    h_key    = hit(addr, A_KEY);
    legal    = mode inside {MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU};
    mis      = (mode[1:0] == 2'b01 && addr[0]) || (mode == MODE_W && addr[1:0] != 2'b00);
    region_d = addr[ADDR_W-1:DMEM_AW] == '0 ? REG_DMEM :
               (h_ledr || h_ledg || h_hexl || h_hexh || h_lcd) ? REG_IO_OUT :
               (h_sw || h_key) ? REG_IO_IN : REG_UNMAPPED;
    st       = req && we && legal && !mis;
    be       = byte_en(mode, addr[1:0]);
    wlane    = mode[1:0] == 2'b00 ? {4{wdata[7:0]}} : mode[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    io_rd    = h_ledr ? ledr_q : h_ledg ? ledg_q : h_hexl ? hexl_q : h_hexh ? hexh_q : h_lcd ? lcd_q :
               h_sw ? sw_q[SYNC_STAGES-1] : h_key ? key_q[SYNC_STAGES-1] : 32'h0;
    word     = region_q == REG_DMEM ? dm_rdata : io_q;
    b        = word[{off_q, 3'b000} +: 8];
    hw       = off_q[1] ? word[31:16] : word[15:0];
    ext      = mode_q == MODE_B  ? {{24{b[7]}}, b} :
               mode_q == MODE_BU ? {24'h0, b} :
               mode_q == MODE_H  ? {{16{hw[15]}}, hw} :
               mode_q == MODE_HU ? {16'h0, hw} :
               mode_q == MODE_W  ? word : 32'h0;
    rdata    = rvalid_q && !mis_q ? ext : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      hexh_q   <= '0;
      hexl_q   <= '0;
      lcd_q    <= '0;
      sw_q     <= '0;
      key_q    <= '0;
      io_q     <= '0;
      mode_q   <= '0;
      off_q    <= '0;
      region_q <= REG_UNMAPPED;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (st && h_ledr) ledr_q <= lane_merge(ledr_q, wlane, be);
      if (st && h_ledg) ledg_q <= lane_merge(ledg_q, wlane, be);
      if (st && h_hexh) hexh_q <= lane_merge(hexh_q, wlane, be);
      if (st && h_hexl) hexl_q <= lane_merge(hexl_q, wlane, be);
      if (st && h_lcd)  lcd_q  <= lane_merge(lcd_q, wlane, be);
      sw_q     <= SYNC_W'({sw_q, SW});
      key_q    <= SYNC_W'({key_q, KEY});
      io_q     <= io_rd;
      mode_q   <= mode;
      off_q    <= addr[1:0];
      region_q <= region_d;
      rvalid_q <= req && (!we || mis);
      mis_q    <= req && mis;
    end
  end
  lsu_dmem #(.DMEM_AW(DMEM_AW)) u_dmem (
    .clk     (clk),
    .en_i    (req && region_d == REG_DMEM),
    .we_i    (st),
    .be_i    (be),
    .addr_i  (addr[DMEM_AW-1:2]),
    .wdata_i (wlane),
    .rdata_o (dm_rdata)
  );
  assign rvalid   = rvalid_q;
  assign misalign = mis_q;
  assign LEDR     = ledr_q;
  assign LEDG     = ledg_q;
  assign HEX_H    = hexh_q;
  assign HEX_L    = hexl_q;
  assign LCD      = lcd_q;
endmodule
